// File: rtl/cam_capture.sv
// ============================================================================
// Module   : cam_capture
// Purpose  : Captures RGB565 camera bytes into a frame buffer with format conversion.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cam_capture #(
    parameter int AW    = 15,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    input  logic          en,
    input  logic          cont,
    input  logic [1:0]    fmt,
    output logic [AW-1:0] mem_px_addr,
    output logic [15:0]   mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic          line_err,
    output logic          odd_err,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_ACTIVE   = 2'd2
    } state_t;

    // One spare bit lets col/row run past the image without wrapping.
    localparam int                CW        = AW + 1;
    localparam logic [CW-1:0]     COL_LIMIT = CW'(IMG_W);
    localparam logic [CW-1:0]     ROW_LIMIT = CW'(IMG_H);
    localparam logic [AW-1:0]     LINE_STEP = AW'(IMG_W);

    state_t          state_q, state_d;
    logic            vsync_q, href_q;
    logic            phase_q, phase_d;
    logic [7:0]      hi_q, hi_d;
    logic [CW-1:0]   col_q, col_d, row_q, row_d;
    logic [AW-1:0]   base_q, base_d;
    logic [1:0]      fmt_q, fmt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic            wr_q, wr_d;
    logic            done_q, done_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            lerr_q, lerr_d;
    logic            oerr_q, oerr_d;

    logic [4:0]      px_r, px_b;
    logic [5:0]      px_g;
    logic [7:0]      r8, g8, b8;
    logic [9:0]      gray_sum;
    logic [15:0]     px_fmt;

    assign px_r     = hi_q[7:3];
    assign px_g     = {hi_q[2:0], px_data[7:5]};
    assign px_b     = px_data[4:0];
    assign r8       = {px_r, px_r[4:2]};
    assign g8       = {px_g, px_g[5:4]};
    assign b8       = {px_b, px_b[4:2]};
    assign gray_sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};

    always_comb begin
        px_fmt = 16'h0000;
        case (fmt_q)
            2'd0:    px_fmt = {8'h00, px_r[4:2], px_g[5:3], px_b[4:3]};
            2'd1:    px_fmt = {4'h0, px_r[4:1], px_g[5:2], px_b[4:1]};
            2'd2:    px_fmt = {hi_q, px_data};
            default: px_fmt = {8'h00, gray_sum[9:2]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        fmt_d   = fmt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        lerr_d  = lerr_q;
        oerr_d  = oerr_q;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (vsync_q && !vsync) begin
                    state_d = S_ACTIVE;
                    phase_d = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = '0;
                    lerr_d  = 1'b0;
                    oerr_d  = 1'b0;
                    fmt_d   = fmt;
                end
            end
            S_ACTIVE: begin
                if (!vsync_q && vsync) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    phase_d = 1'b0;
                    state_d = (en && cont) ? S_WAIT_SOF : S_IDLE;
                end else if (href && !vsync) begin
                    if (!phase_q) begin
                        hi_d    = px_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q < COL_LIMIT && row_q < ROW_LIMIT) begin
                            wr_d   = 1'b1;
                            addr_d = base_q + col_q[AW-1:0];
                            data_d = px_fmt;
                        end
                        if (col_q != '1) col_d = col_q + CW'(1);
                    end
                end else if (!href) begin
                    phase_d = 1'b0;
                    // Only a line that delivered at least one pixel ends a row.
                    if (href_q && col_q != '0) begin
                        col_d  = '0;
                        base_d = base_q + LINE_STEP;
                        if (row_q != '1) row_d = row_q + CW'(1);
                        if (col_q != COL_LIMIT) lerr_d = 1'b1;
                        if (phase_q) oerr_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            fmt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            lerr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            href_q  <= href;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            fmt_q   <= fmt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            lerr_q  <= lerr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign mem_px_addr = addr_q;
    assign mem_px_data = data_q;
    assign px_wr       = wr_q;
    assign frame_done  = done_q;
    assign frame_cnt   = cnt_q;
    assign line_err    = lerr_q;
    assign odd_err     = oerr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire
